// File: rtl/decode_if.sv
// Fetch/execute/write-back bundle of the registered decode stage.
// The stage uses the slave side; whatever drives fetch and consumes execute uses master.
interface decode_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32
);
    logic [15:0]       i_instr;
    logic              i_instr_valid;
    logic [PC_W-1:0]   i_pc;
    logic              i_ex_ready;
    logic              i_flush;
    logic              i_write_back;
    logic [2:0]        i_write_addr;
    logic [DATA_W-1:0] i_write_data;

    logic              o_stall;
    logic              o_valid;
    logic [4:0]        o_op_code;
    logic [2:0]        o_rd;
    logic [2:0]        o_rs;
    logic [DATA_W-1:0] o_data1;
    logic [DATA_W-1:0] o_data2;
    logic              o_has_imm;
    logic [DATA_W-1:0] o_imm;
    logic              o_mem_read;
    logic [PC_W-1:0]   o_pc;

    modport master (
        output i_instr, i_instr_valid, i_pc, i_ex_ready, i_flush,
        output i_write_back, i_write_addr, i_write_data,
        input  o_stall, o_valid, o_op_code, o_rd, o_rs, o_data1,
        input  o_data2, o_has_imm, o_imm, o_mem_read, o_pc
    );

    modport slave (
        input  i_instr, i_instr_valid, i_pc, i_ex_ready, i_flush,
        input  i_write_back, i_write_addr, i_write_data,
        output o_stall, o_valid, o_op_code, o_rd, o_rs, o_data1,
        output o_data2, o_has_imm, o_imm, o_mem_read, o_pc
    );
endinterface

// File: rtl/decode_stage_hs.sv
// Registered decode stage: register file with write-through bypass,
// two-word instruction assembly, load-use bubbling and synchronous flush.
module decode_stage_hs #(
    parameter int         DATA_W  = 16,
    parameter int         PC_W    = 32,
    parameter int         REG_CNT = 8,
    parameter logic [4:0] LOAD_OP = 5'b10100
) (
    input  logic    i_clk,
    input  logic    i_reset,
    decode_if.slave bus
);
    localparam int AW = $clog2(REG_CNT);

    typedef enum logic {S_DECODE, S_IMM} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    logic              hold_vld_q, hold_vld_d;
    logic [4:0]        hold_op_q, hold_op_d;
    logic [2:0]        hold_rd_q, hold_rd_d;
    logic [2:0]        hold_rs_q, hold_rs_d;
    logic [PC_W-1:0]   hold_pc_q, hold_pc_d;

    logic              valid_q, valid_d;
    logic [4:0]        op_q, op_d;
    logic [2:0]        rd_q, rd_d;
    logic [2:0]        rs_q, rs_d;
    logic [DATA_W-1:0] data1_q, data1_d;
    logic [DATA_W-1:0] data2_q, data2_d;
    logic              has_imm_q, has_imm_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              mem_rd_q, mem_rd_d;
    logic [PC_W-1:0]   pc_q, pc_d;

    logic              adv, haz, consume;
    logic [4:0]        cand_op;
    logic [2:0]        cand_rd, cand_rs;
    logic [DATA_W-1:0] rdata1, rdata2;

    function automatic logic [DATA_W-1:0] rf_read(input logic [2:0] a);
        if (bus.i_write_back && bus.i_write_addr[AW-1:0] == a[AW-1:0])
            return bus.i_write_data;
        return regs_q[a[AW-1:0]];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (bus.i_write_back)
            regs_d[bus.i_write_addr[AW-1:0]] = bus.i_write_data;
    end

    // In S_IMM the instruction under decode is the held first word
    always_comb begin
        cand_op = bus.i_instr[15:11];
        cand_rd = bus.i_instr[10:8];
        cand_rs = bus.i_instr[7:5];
        if (state_q == S_IMM) begin
            cand_op = hold_op_q;
            cand_rd = hold_rd_q;
            cand_rs = hold_rs_q;
        end
    end

    assign rdata1 = rf_read(cand_rd);
    assign rdata2 = rf_read(cand_rs);
    assign adv    = !valid_q || bus.i_ex_ready;
    assign haz    = valid_q && mem_rd_q &&
                    (cand_rd == rd_q || cand_rs == rd_q);

    always_comb begin
        state_d    = state_q;
        hold_vld_d = hold_vld_q;
        hold_op_d  = hold_op_q;
        hold_rd_d  = hold_rd_q;
        hold_rs_d  = hold_rs_q;
        hold_pc_d  = hold_pc_q;
        valid_d    = valid_q;
        op_d       = op_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        data1_d    = data1_q;
        data2_d    = data2_q;
        has_imm_d  = has_imm_q;
        imm_d      = imm_q;
        mem_rd_d   = mem_rd_q;
        pc_d       = pc_q;
        consume    = 1'b0;

        if (bus.i_flush) begin
            valid_d    = 1'b0;
            state_d    = S_DECODE;
            hold_vld_d = 1'b0;
        end else begin
            // Advancing without issuing leaves a bubble behind
            if (adv)
                valid_d = 1'b0;
            unique case (state_q)
                S_DECODE: begin
                    if (bus.i_instr_valid) begin
                        if (cand_op[4:3] == 2'b11) begin
                            if (!(haz && adv)) begin
                                consume    = 1'b1;
                                hold_vld_d = 1'b1;
                                hold_op_d  = cand_op;
                                hold_rd_d  = cand_rd;
                                hold_rs_d  = cand_rs;
                                hold_pc_d  = bus.i_pc;
                                state_d    = S_IMM;
                            end
                        end else if (adv && !haz) begin
                            consume   = 1'b1;
                            valid_d   = 1'b1;
                            op_d      = cand_op;
                            rd_d      = cand_rd;
                            rs_d      = cand_rs;
                            data1_d   = rdata1;
                            data2_d   = rdata2;
                            has_imm_d = 1'b0;
                            imm_d     = '0;
                            mem_rd_d  = (cand_op == LOAD_OP);
                            pc_d      = bus.i_pc;
                        end
                    end
                end
                S_IMM: begin
                    if (bus.i_instr_valid && adv && !haz) begin
                        consume    = 1'b1;
                        valid_d    = 1'b1;
                        op_d       = cand_op;
                        rd_d       = cand_rd;
                        rs_d       = cand_rs;
                        data1_d    = rdata1;
                        data2_d    = rdata2;
                        has_imm_d  = 1'b1;
                        imm_d      = DATA_W'(bus.i_instr);
                        mem_rd_d   = (cand_op == LOAD_OP);
                        pc_d       = hold_pc_q;
                        hold_vld_d = 1'b0;
                        state_d    = S_DECODE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < REG_CNT; i++)
                regs_q[i] <= '0;
            state_q    <= S_DECODE;
            hold_vld_q <= 1'b0;
            hold_op_q  <= '0;
            hold_rd_q  <= '0;
            hold_rs_q  <= '0;
            hold_pc_q  <= '0;
            valid_q    <= 1'b0;
            op_q       <= '0;
            rd_q       <= '0;
            rs_q       <= '0;
            data1_q    <= '0;
            data2_q    <= '0;
            has_imm_q  <= 1'b0;
            imm_q      <= '0;
            mem_rd_q   <= 1'b0;
            pc_q       <= '0;
        end else begin
            regs_q     <= regs_d;
            state_q    <= state_d;
            hold_vld_q <= hold_vld_d;
            hold_op_q  <= hold_op_d;
            hold_rd_q  <= hold_rd_d;
            hold_rs_q  <= hold_rs_d;
            hold_pc_q  <= hold_pc_d;
            valid_q    <= valid_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs_q       <= rs_d;
            data1_q    <= data1_d;
            data2_q    <= data2_d;
            has_imm_q  <= has_imm_d;
            imm_q      <= imm_d;
            mem_rd_q   <= mem_rd_d;
            pc_q       <= pc_d;
        end
    end

    assign bus.o_stall    = bus.i_instr_valid && !consume &&
                            !bus.i_flush && !i_reset;
    assign bus.o_valid    = valid_q;
    assign bus.o_op_code  = op_q;
    assign bus.o_rd       = rd_q;
    assign bus.o_rs       = rs_q;
    assign bus.o_data1    = data1_q;
    assign bus.o_data2    = data2_q;
    assign bus.o_has_imm  = has_imm_q;
    assign bus.o_imm      = imm_q;
    assign bus.o_mem_read = mem_rd_q;
    assign bus.o_pc       = pc_q;
endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed bench for decode_stage_hs: reset, bypass, two-word assembly,
// load-use bubble, back-pressure and flush.
module tb_decode_stage_hs;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    decode_if #(.DATA_W(16), .PC_W(32)) bus ();

    decode_stage_hs #(
        .DATA_W(16), .PC_W(32), .REG_CNT(8), .LOAD_OP(5'b10100)
    ) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] w, input logic [31:0] pc);
        bus.i_instr_valid = v;
        bus.i_instr       = w;
        bus.i_pc          = pc;
    endtask

    task automatic test_reset;
        #3;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL por_valid got %h want 0", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h0) $display("FAIL por_pc got %h want 0", bus.o_pc); else pass_cnt++;
        tick;
        rst = 1'b0;
        bus.i_write_back = 1'b1; bus.i_write_addr = 3'd3; bus.i_write_data = 16'hAAAA;
        drive(1'b1, 16'h0B60, 32'h10);
        tick;
        bus.i_write_back = 1'b0;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL rst_pre_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_data1 !== 16'hAAAA) $display("FAIL rst_pre_data1 got %h want aaaa", bus.o_data1); else pass_cnt++;
        drive(1'b1, 16'hC100, 32'h14);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL rst_imm_valid got %h want 0", bus.o_valid); else pass_cnt++;
        drive(1'b0, 16'h0, 32'h0);
        rst = 1'b1;
        #2;
        tot_cnt++; if (bus.o_op_code !== 5'd0) $display("FAIL rst_op got %h want 0", bus.o_op_code); else pass_cnt++;
        tot_cnt++; if (bus.o_rd !== 3'd0) $display("FAIL rst_rd got %h want 0", bus.o_rd); else pass_cnt++;
        tot_cnt++; if (bus.o_data1 !== 16'h0) $display("FAIL rst_data1 got %h want 0", bus.o_data1); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h0) $display("FAIL rst_pc got %h want 0", bus.o_pc); else pass_cnt++;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL rst_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        rst = 1'b0;
        drive(1'b1, 16'h0B60, 32'h20);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL rst_post_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL rst_post_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_data1 !== 16'h0) $display("FAIL rst_reg3 got %h want 0", bus.o_data1); else pass_cnt++;
        tot_cnt++; if (bus.o_has_imm !== 1'b0) $display("FAIL rst_post_has_imm got %h want 0", bus.o_has_imm); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h20) $display("FAIL rst_post_pc got %h want 20", bus.o_pc); else pass_cnt++;
    endtask

    task automatic test_bypass;
        bus.i_write_back = 1'b1; bus.i_write_addr = 3'd2; bus.i_write_data = 16'hBEEF;
        drive(1'b1, 16'h0940, 32'h30);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL byp_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL byp_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_data2 !== 16'hBEEF) $display("FAIL byp_data2 got %h want beef", bus.o_data2); else pass_cnt++;
        tot_cnt++; if (bus.o_rs !== 3'd2) $display("FAIL byp_rs got %h want 2", bus.o_rs); else pass_cnt++;
        bus.i_write_back = 1'b0;
        drive(1'b1, 16'h0940, 32'h32);
        tick;
        tot_cnt++; if (bus.o_data2 !== 16'hBEEF) $display("FAIL rf_data2 got %h want beef", bus.o_data2); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h32) $display("FAIL rf_pc got %h want 32", bus.o_pc); else pass_cnt++;
    endtask

    task automatic test_two_word;
        drive(1'b1, 16'hC100, 32'h40);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL tw1_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL tw_gap_valid got %h want 0", bus.o_valid); else pass_cnt++;
        drive(1'b1, 16'h1234, 32'h42);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL tw2_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL tw_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_has_imm !== 1'b1) $display("FAIL tw_has_imm got %h want 1", bus.o_has_imm); else pass_cnt++;
        tot_cnt++; if (bus.o_imm !== 16'h1234) $display("FAIL tw_imm got %h want 1234", bus.o_imm); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h40) $display("FAIL tw_pc got %h want 40", bus.o_pc); else pass_cnt++;
        tot_cnt++; if (bus.o_rd !== 3'd1) $display("FAIL tw_rd got %h want 1", bus.o_rd); else pass_cnt++;
        tot_cnt++; if (bus.o_op_code !== 5'b11000) $display("FAIL tw_op got %h want 18", bus.o_op_code); else pass_cnt++;
        drive(1'b0, 16'h0, 32'h0);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL tw_once got %h want 0", bus.o_valid); else pass_cnt++;
    endtask

    task automatic test_load_use;
        drive(1'b1, 16'hA500, 32'h50);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL ld_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_mem_read !== 1'b1) $display("FAIL ld_mem_read got %h want 1", bus.o_mem_read); else pass_cnt++;
        drive(1'b1, 16'h09A0, 32'h52);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b1) $display("FAIL lu_stall got %h want 1", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL lu_bubble got %h want 0", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_rd !== 3'd5) $display("FAIL lu_rd_hold got %h want 5", bus.o_rd); else pass_cnt++;
        bus.i_write_back = 1'b1; bus.i_write_addr = 3'd5; bus.i_write_data = 16'h5555;
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL lu_retry_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        bus.i_write_back = 1'b0;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL lu_issue got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_data2 !== 16'h5555) $display("FAIL lu_data2 got %h want 5555", bus.o_data2); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h52) $display("FAIL lu_pc got %h want 52", bus.o_pc); else pass_cnt++;
        tot_cnt++; if (bus.o_mem_read !== 1'b0) $display("FAIL lu_mem_read got %h want 0", bus.o_mem_read); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        drive(1'b1, 16'h0940, 32'h60);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL bp_first got %h want 1", bus.o_valid); else pass_cnt++;
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 16'h1A40, 32'h62);
        for (int i = 0; i < 3; i++) begin
            #1;
            tot_cnt++; if (bus.o_stall !== 1'b1) $display("FAIL bp_stall%0d got %h want 1", i, bus.o_stall); else pass_cnt++;
            tick;
            tot_cnt++; if (bus.o_pc !== 32'h60) $display("FAIL bp_pc%0d got %h want 60", i, bus.o_pc); else pass_cnt++;
            tot_cnt++; if (bus.o_op_code !== 5'd1) $display("FAIL bp_op%0d got %h want 1", i, bus.o_op_code); else pass_cnt++;
            tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL bp_valid%0d got %h want 1", i, bus.o_valid); else pass_cnt++;
        end
        bus.i_ex_ready = 1'b1;
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL bp_release got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_op_code !== 5'd3) $display("FAIL bp_next_op got %h want 3", bus.o_op_code); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h62) $display("FAIL bp_next_pc got %h want 62", bus.o_pc); else pass_cnt++;
        drive(1'b0, 16'h0, 32'h0);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL bp_once got %h want 0", bus.o_valid); else pass_cnt++;
    endtask

    task automatic test_flush;
        drive(1'b1, 16'h0940, 32'h70);
        tick;
        bus.i_ex_ready = 1'b0;
        drive(1'b1, 16'hC100, 32'h72);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL fl_first_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL fl_hold_valid got %h want 1", bus.o_valid); else pass_cnt++;
        bus.i_flush = 1'b1;
        drive(1'b1, 16'h1234, 32'h74);
        #1;
        tot_cnt++; if (bus.o_stall !== 1'b0) $display("FAIL fl_stall got %h want 0", bus.o_stall); else pass_cnt++;
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b0) $display("FAIL fl_valid got %h want 0", bus.o_valid); else pass_cnt++;
        bus.i_flush = 1'b0;
        bus.i_ex_ready = 1'b1;
        drive(1'b1, 16'h1A40, 32'h76);
        tick;
        tot_cnt++; if (bus.o_valid !== 1'b1) $display("FAIL fl_next_valid got %h want 1", bus.o_valid); else pass_cnt++;
        tot_cnt++; if (bus.o_has_imm !== 1'b0) $display("FAIL fl_next_has_imm got %h want 0", bus.o_has_imm); else pass_cnt++;
        tot_cnt++; if (bus.o_imm !== 16'h0) $display("FAIL fl_next_imm got %h want 0", bus.o_imm); else pass_cnt++;
        tot_cnt++; if (bus.o_pc !== 32'h76) $display("FAIL fl_next_pc got %h want 76", bus.o_pc); else pass_cnt++;
        drive(1'b0, 16'h0, 32'h0);
        tick;
    endtask

    initial begin
        bus.i_ex_ready   = 1'b1;
        bus.i_flush      = 1'b0;
        bus.i_write_back = 1'b0;
        bus.i_write_addr = 3'd0;
        bus.i_write_data = 16'h0;
        drive(1'b0, 16'h0, 32'h0);
        test_reset;
        test_bypass;
        test_two_word;
        test_load_use;
        test_back_to_back;
        test_flush;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
